fetch_stage: RTL and testbench

Instruction-fetch stage of the JOF32 five-stage pipeline. It holds the program counter, drives the instruction-memory address, and registers the fetched word plus its PC into the IF/ID pipeline register. It presents the 5-bit opcode field to the decode-stage control unit. It applies the PC source selection (`sel_dir`: sequential / branch / jump) returned by later stages, and supports stall (hold) and squash (bubble insertion as the NOP opcode 5'b11111).

---
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// JOF32 instruction-fetch stage: program counter, instruction-memory address,
// IF/ID pipeline register, redirect/stall/squash handling and fetch statistics.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'hF800_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  sel_dir,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic [31:0] pc_plus4_id,
  output logic [4:0]  opcode_id,
  output logic        valid_id,
  output logic        redirect,
  output logic [31:0] fetch_count,
  output logic [15:0] squash_count
);

  typedef enum logic [1:0] {
    RESET_FILL,
    RUN,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        take;
  logic        load_if;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RESET_FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RESET_FILL: state_next = RUN;
      RUN:        state_next = stall ? HOLD : RUN;
      HOLD:       state_next = stall ? HOLD : RUN;
      default:    state_next = RESET_FILL;
    endcase
  end

  // A redirect outranks a stall, so the IF/ID load is only enabled when neither applies.
  always_comb begin
    take    = (sel_dir == 2'b10) || ((sel_dir == 2'b01) && branch_taken);
    load_if = !take && !stall;
  end

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  always_comb begin
    pc_next = pc_plus4;
    if (take && (sel_dir == 2'b10)) begin
      pc_next = jump_target & 32'hFFFF_FFFC;
    end else if (take) begin
      pc_next = branch_target & 32'hFFFF_FFFC;
    end else if (stall) begin
      pc_next = pc;
    end
  end

  // On a redirect the bubble keeps the previous pc_id/pc_plus4_id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_PC;
      instr_id     <= NOP_WORD;
      opcode_id    <= 5'b11111;
      pc_id        <= 32'd0;
      pc_plus4_id  <= 32'd0;
      valid_id     <= 1'b0;
      redirect     <= 1'b0;
      fetch_count  <= 32'd0;
      squash_count <= 16'd0;
    end else begin
      pc       <= pc_next;
      redirect <= take;
      if (take) begin
        instr_id     <= NOP_WORD;
        opcode_id    <= 5'b11111;
        valid_id     <= 1'b0;
        squash_count <= squash_count + 16'd1;
      end else if (load_if) begin
        instr_id    <= imem_rdata;
        opcode_id   <= imem_rdata[31:27];
        pc_id       <= pc;
        pc_plus4_id <= pc_plus4;
        valid_id    <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a spec-level model predicts the IF/ID state
// after every edge, and a negedge monitor compares it against the DUT.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hF800_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  sel_dir;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_id;
  logic [31:0] pc_id;
  logic [31:0] pc_plus4_id;
  logic [4:0]  opcode_id;
  logic        valid_id;
  logic        redirect;
  logic [31:0] fetch_count;
  logic [15:0] squash_count;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  opc;
    logic        valid;
    logic        redir;
    logic [31:0] fcount;
    logic [15:0] scount;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: what the IF/ID register and counters should hold.
  logic [31:0] m_pc, m_instr, m_pc_id, m_pc4, m_fcount;
  logic [15:0] m_scount;
  logic        m_valid, m_redir;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .sel_dir(sel_dir),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_target(jump_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_id(instr_id), .pc_id(pc_id), .pc_plus4_id(pc_plus4_id),
    .opcode_id(opcode_id), .valid_id(valid_id), .redirect(redirect),
    .fetch_count(fetch_count), .squash_count(squash_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: ADD/SUB/OR at 0/4/8, hashed words elsewhere.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0001;
      32'h4:   return 32'h0800_0002;
      32'h8:   return 32'h1800_0003;
      default: return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endcase
  endfunction

  assign imem_rdata = memWord(imem_addr);

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic resetModel();
    m_pc = 32'h0; m_instr = NOP; m_pc_id = 32'h0; m_pc4 = 32'h0;
    m_fcount = 32'h0; m_scount = 16'h0; m_valid = 1'b0; m_redir = 1'b0;
  endtask

  task automatic checkReset();
    cmp("rst_imem_addr", imem_addr, 32'h0);
    cmp("rst_instr_id", instr_id, NOP);
    cmp("rst_opcode_id", {27'd0, opcode_id}, 32'h1F);
    cmp("rst_pc_id", pc_id, 32'h0);
    cmp("rst_pc_plus4_id", pc_plus4_id, 32'h0);
    cmp("rst_valid_id", {31'd0, valid_id}, 32'h0);
    cmp("rst_redirect", {31'd0, redirect}, 32'h0);
    cmp("rst_fetch_count", fetch_count, 32'h0);
    cmp("rst_squash_count", {16'd0, squash_count}, 32'h0);
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("imem_addr", imem_addr, e.addr);
    cmp("instr_id", instr_id, e.instr);
    cmp("pc_id", pc_id, e.pc);
    cmp("pc_plus4_id", pc_plus4_id, e.pc4);
    cmp("opcode_id", {27'd0, opcode_id}, {27'd0, e.opc});
    cmp("valid_id", {31'd0, valid_id}, {31'd0, e.valid});
    cmp("redirect", {31'd0, redirect}, {31'd0, e.redir});
    cmp("fetch_count", fetch_count, e.fcount);
    cmp("squash_count", {16'd0, squash_count}, {16'd0, e.scount});
  endtask

  // Drive one cycle of inputs, advance the model by one edge, queue the prediction.
  task automatic applyStimulus(input logic st, input logic [1:0] sel, input logic bt,
                               input logic [31:0] btgt, input logic [31:0] jtgt);
    logic take;
    exp_t e;
    stall = st; sel_dir = sel; branch_taken = bt;
    branch_target = btgt; jump_target = jtgt;
    take = (sel == 2'b10) || (sel == 2'b01 && bt);
    if (take) begin
      m_instr = NOP;
      m_valid = 1'b0;
      m_scount = m_scount + 16'd1;
      m_pc = ((sel == 2'b10) ? jtgt : btgt) & ~32'h3;
    end else if (!st) begin
      m_instr  = memWord(m_pc);
      m_pc_id  = m_pc;
      m_pc4    = m_pc + 32'd4;
      m_valid  = 1'b1;
      m_fcount = m_fcount + 32'd1;
      m_pc     = m_pc + 32'd4;
    end
    m_redir = take;
    e.addr = m_pc; e.instr = m_instr; e.pc = m_pc_id; e.pc4 = m_pc4;
    e.opc = m_instr[31:27]; e.valid = m_valid; e.redir = m_redir;
    e.fcount = m_fcount; e.scount = m_scount;
    exp_q.push_back(e);
    @(negedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; sel_dir = 2'b00; branch_taken = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
    #1;
    checkReset();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    resetModel();

    applyStimulus(0, 2'b00, 0, 0, 0);
    applyStimulus(0, 2'b00, 0, 0, 0);
    applyStimulus(0, 2'b10, 0, 0, 32'h40);
    applyStimulus(0, 2'b00, 0, 0, 0);
    applyStimulus(0, 2'b01, 0, 32'h80, 0);
    applyStimulus(0, 2'b01, 1, 32'h100, 0);
    applyStimulus(0, 2'b00, 0, 0, 0);
    applyStimulus(0, 2'b10, 0, 0, 32'h10);
    repeat (3) applyStimulus(1, 2'b00, 0, 0, 0);
    applyStimulus(0, 2'b00, 0, 0, 0);
    applyStimulus(0, 2'b00, 0, 0, 0);
    applyStimulus(1, 2'b10, 0, 0, 32'h200);
    applyStimulus(0, 2'b00, 0, 0, 0);
    applyStimulus(0, 2'b10, 0, 0, 32'hFFFF_FFFC);
    applyStimulus(0, 2'b00, 0, 0, 0);
    applyStimulus(0, 2'b00, 0, 0, 0);
    applyStimulus(0, 2'b11, 1, 32'h500, 32'h600);
    applyStimulus(0, 2'b01, 1, 32'h0000_0707, 0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] t1, t2;
      t1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      t2 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF9 : $urandom;
      applyStimulus($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), t1, t2);
    end

    // Asynchronous reset in the middle of a cycle that is requesting a jump.
    @(negedge clk); #1;
    stall = 1'b1; sel_dir = 2'b10; jump_target = 32'h300;
    #2;
    rst = 1'b1;
    #1;
    checkReset();
    @(negedge clk); #1;
    rst = 1'b0;
    resetModel();
    repeat (4) applyStimulus(0, 2'b00, 0, 0, 0);
    applyStimulus(0, 2'b01, 1, 32'h24, 0);
    applyStimulus(0, 2'b00, 0, 0, 0);

    @(negedge clk); #1;
    cmp("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
